// File: rtl/sap1_controller_if.sv
// Control-word bundle driven by the SAP-1 sequencer toward the datapath registers.
// Names ending in _n are active-low.
interface sap1_controller_if;
  logic       pc_inc;
  logic       pc_en;
  logic       mar_ld_n;
  logic       ram_en_n;
  logic       ir_ld_n;
  logic       ir_en_n;
  logic       a_ld_n;
  logic       a_en;
  logic       b_ld_n;
  logic       alu_sub;
  logic       alu_en;
  logic       out_ld_n;
  logic       hlt;
  logic [5:0] t_state;

  modport master (
    output pc_inc, pc_en, mar_ld_n, ram_en_n, ir_ld_n, ir_en_n, a_ld_n, a_en, b_ld_n,
           alu_sub, alu_en, out_ld_n, hlt, t_state
  );

  modport slave (
    input pc_inc, pc_en, mar_ld_n, ram_en_n, ir_ld_n, ir_en_n, a_ld_n, a_en, b_ld_n,
          alu_sub, alu_en, out_ld_n, hlt, t_state
  );
endinterface

// File: rtl/sap1_controller.sv
// SAP-1 control sequencer: one-hot T1..T6 ring plus halt flag, combinational microcode decode.
// Optional manual stepping (step_i port) is enabled by defining SAP1_CTRL_STEP_EN.
module sap1_controller #(
  parameter logic [3:0] OP_LDA = 4'h0,
  parameter logic [3:0] OP_ADD = 4'h1,
  parameter logic [3:0] OP_SUB = 4'h2,
  parameter logic [3:0] OP_OUT = 4'hE,
  parameter logic [3:0] OP_HLT = 4'hF
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
`ifdef SAP1_CTRL_STEP_EN
  input  logic                  step_i,
`endif
  input  logic [3:0]            opcode_i,
  sap1_controller_if.master     ctrl
);

  typedef enum logic [5:0] {
    StT1 = 6'b000001,
    StT2 = 6'b000010,
    StT3 = 6'b000100,
    StT4 = 6'b001000,
    StT5 = 6'b010000,
    StT6 = 6'b100000
  } ring_e;

  ring_e ring_q, ring_d;
  logic  halt_q, halt_d;
  logic  adv;

`ifdef SAP1_CTRL_STEP_EN
  assign adv = step_i;
`else
  assign adv = 1'b1;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ring_q <= StT1;
      halt_q <= 1'b0;
    end else begin
      ring_q <= ring_d;
      halt_q <= halt_d;
    end
  end

  // HLT in T4 latches the halt flag instead of advancing, parking the ring at T4.
  always_comb begin
    ring_d = ring_q;
    halt_d = halt_q;
    if (!halt_q && adv) begin
      unique case (ring_q)
        StT1:    ring_d = StT2;
        StT2:    ring_d = StT3;
        StT3:    ring_d = StT4;
        StT4: begin
          if (opcode_i == OP_HLT) halt_d = 1'b1;
          else                    ring_d = StT5;
        end
        StT5:    ring_d = StT6;
        StT6:    ring_d = StT1;
        default: ring_d = StT1;
      endcase
    end
  end

  logic pc_inc, pc_en, mar_ld_n, ram_en_n, ir_ld_n, ir_en_n;
  logic a_ld_n, a_en, b_ld_n, alu_sub, alu_en, out_ld_n, hlt;

  always_comb begin
    pc_inc   = 1'b0;
    pc_en    = 1'b0;
    mar_ld_n = 1'b1;
    ram_en_n = 1'b1;
    ir_ld_n  = 1'b1;
    ir_en_n  = 1'b1;
    a_ld_n   = 1'b1;
    a_en     = 1'b0;
    b_ld_n   = 1'b1;
    alu_sub  = 1'b0;
    alu_en   = 1'b0;
    out_ld_n = 1'b1;
    hlt      = 1'b0;

    unique case (ring_q)
      StT1: begin
        pc_en    = 1'b1;
        mar_ld_n = 1'b0;
      end
      StT2: pc_inc = 1'b1;
      StT3: begin
        ram_en_n = 1'b0;
        ir_ld_n  = 1'b0;
      end
      StT4: begin
        if (opcode_i == OP_LDA || opcode_i == OP_ADD || opcode_i == OP_SUB) begin
          ir_en_n  = 1'b0;
          mar_ld_n = 1'b0;
        end else if (opcode_i == OP_OUT) begin
          a_en     = 1'b1;
          out_ld_n = 1'b0;
        end else if (opcode_i == OP_HLT) begin
          hlt = 1'b1;
        end
      end
      StT5: begin
        if (opcode_i == OP_LDA) begin
          ram_en_n = 1'b0;
          a_ld_n   = 1'b0;
        end else if (opcode_i == OP_ADD || opcode_i == OP_SUB) begin
          ram_en_n = 1'b0;
          b_ld_n   = 1'b0;
          alu_sub  = (opcode_i == OP_SUB);
        end
      end
      StT6: begin
        if (opcode_i == OP_ADD || opcode_i == OP_SUB) begin
          alu_en  = 1'b1;
          a_ld_n  = 1'b0;
          alu_sub = (opcode_i == OP_SUB);
        end
      end
      default: ;
    endcase

    // Reset and halt both silence the whole word; halt keeps only hlt raised.
    if (rst_i || halt_q) begin
      pc_inc   = 1'b0;
      pc_en    = 1'b0;
      mar_ld_n = 1'b1;
      ram_en_n = 1'b1;
      ir_ld_n  = 1'b1;
      ir_en_n  = 1'b1;
      a_ld_n   = 1'b1;
      a_en     = 1'b0;
      b_ld_n   = 1'b1;
      alu_sub  = 1'b0;
      alu_en   = 1'b0;
      out_ld_n = 1'b1;
      hlt      = halt_q && !rst_i;
    end

    // Without a step strobe no register may reload; enables stay as decoded.
    if (!adv) begin
      mar_ld_n = 1'b1;
      ir_ld_n  = 1'b1;
      a_ld_n   = 1'b1;
      b_ld_n   = 1'b1;
      out_ld_n = 1'b1;
    end
  end

  assign ctrl.pc_inc   = pc_inc;
  assign ctrl.pc_en    = pc_en;
  assign ctrl.mar_ld_n = mar_ld_n;
  assign ctrl.ram_en_n = ram_en_n;
  assign ctrl.ir_ld_n  = ir_ld_n;
  assign ctrl.ir_en_n  = ir_en_n;
  assign ctrl.a_ld_n   = a_ld_n;
  assign ctrl.a_en     = a_en;
  assign ctrl.b_ld_n   = b_ld_n;
  assign ctrl.alu_sub  = alu_sub;
  assign ctrl.alu_en   = alu_en;
  assign ctrl.out_ld_n = out_ld_n;
  assign ctrl.hlt      = hlt;
  assign ctrl.t_state  = ring_q;

endmodule

// File: tb/tb_sap1_controller.sv
// Directed bench for sap1_controller: fetch/execute words per opcode, reset abort, halt, stepping.
module tb_sap1_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] opcode;
`ifdef SAP1_CTRL_STEP_EN
  logic       step;
`endif

  sap1_controller_if ctrl ();

  sap1_controller dut (
    .clk_i    (clk),
`ifdef SAP1_CTRL_STEP_EN
    .step_i   (step),
`endif
    .rst_i    (rst),
    .opcode_i (opcode),
    .ctrl     (ctrl)
  );

  always #5 clk = ~clk;

  localparam logic [11:0] Idle    = 12'h3E9;
  localparam logic [11:0] MPcInc  = 12'h800;
  localparam logic [11:0] MPcEn   = 12'h400;
  localparam logic [11:0] MMar    = 12'h200;
  localparam logic [11:0] MRam    = 12'h100;
  localparam logic [11:0] MIrLd   = 12'h080;
  localparam logic [11:0] MIrEn   = 12'h040;
  localparam logic [11:0] MALd    = 12'h020;
  localparam logic [11:0] MAEn    = 12'h010;
  localparam logic [11:0] MBLd    = 12'h008;
  localparam logic [11:0] MSub    = 12'h004;
  localparam logic [11:0] MAluEn  = 12'h002;
  localparam logic [11:0] MOut    = 12'h001;

  localparam logic [11:0] WT1 = Idle ^ MPcEn ^ MMar;
  localparam logic [11:0] WT2 = Idle ^ MPcInc;
  localparam logic [11:0] WT3 = Idle ^ MRam ^ MIrLd;

  logic [11:0] cw;
  assign cw = {ctrl.pc_inc, ctrl.pc_en, ctrl.mar_ld_n, ctrl.ram_en_n, ctrl.ir_ld_n,
               ctrl.ir_en_n, ctrl.a_ld_n, ctrl.a_en, ctrl.b_ld_n, ctrl.alu_sub,
               ctrl.alu_en, ctrl.out_ld_n};

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic [5:0] ts, input logic [11:0] word,
                             input logic hlt);
    int drivers;
    drivers = int'(ctrl.pc_en) + int'(!ctrl.ram_en_n) + int'(!ctrl.ir_en_n) + int'(ctrl.a_en)
              + int'(ctrl.alu_en);
    check_eq({tag, ".t_state"}, 32'(ctrl.t_state), 32'(ts));
    check_eq({tag, ".word"}, 32'(cw), 32'(word));
    check_eq({tag, ".hlt"}, 32'(ctrl.hlt), 32'(hlt));
    check_eq({tag, ".bus"}, 32'(drivers <= 1), 32'd1);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expects to start in T1; leaves the ring back in T1.
  task automatic run_instr(input string name, input logic [3:0] op, input logic [11:0] w4,
                           input logic [11:0] w5, input logic [11:0] w6);
    logic [11:0] w [6];
    w = '{WT1, WT2, WT3, w4, w5, w6};
    opcode = op;
    for (int k = 0; k < 6; k++) begin
      #1;
      check_state($sformatf("%s.T%0d", name, k + 1), 6'd1 << k, w[k], 1'b0);
      tick();
    end
  endtask

  initial begin
    rst    = 1'b1;
    opcode = 4'h0;
`ifdef SAP1_CTRL_STEP_EN
    step   = 1'b1;
`endif
    #12;
    check_state("reset", 6'b000001, Idle, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_state("release", 6'b000001, WT1, 1'b0);

    run_instr("lda", 4'h0, Idle ^ MIrEn ^ MMar, Idle ^ MRam ^ MALd, Idle);
    run_instr("add", 4'h1, Idle ^ MIrEn ^ MMar, Idle ^ MRam ^ MBLd, Idle ^ MAluEn ^ MALd);
    run_instr("sub", 4'h2, Idle ^ MIrEn ^ MMar, Idle ^ MRam ^ MBLd ^ MSub,
              Idle ^ MAluEn ^ MALd ^ MSub);
    run_instr("out", 4'hE, Idle ^ MAEn ^ MOut, Idle, Idle);
    run_instr("nop7", 4'h7, Idle, Idle, Idle);
    check_state("after_nop", 6'b000001, WT1, 1'b0);

    // Abort an LDA in T5 with an asynchronous reset.
    opcode = 4'h0;
    repeat (4) tick();
    check_state("lda_t5", 6'b010000, Idle ^ MRam ^ MALd, 1'b0);
    rst = 1'b1;
    #1;
    check_state("rst_mid", 6'b000001, Idle, 1'b0);
    tick();
    check_state("rst_hold", 6'b000001, Idle, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_state("rst_release", 6'b000001, WT1, 1'b0);
    run_instr("lda2", 4'h0, Idle ^ MIrEn ^ MMar, Idle ^ MRam ^ MALd, Idle);

    // Halt: T4 raises hlt combinationally, then ring parks at T4.
    opcode = 4'hF;
    #1;
    check_state("hlt.T1", 6'b000001, WT1, 1'b0);
    tick();
    check_state("hlt.T2", 6'b000010, WT2, 1'b0);
    tick();
    check_state("hlt.T3", 6'b000100, WT3, 1'b0);
    tick();
    check_state("hlt.T4", 6'b001000, Idle, 1'b1);
    tick();
    opcode = 4'h0;
    for (int i = 0; i < 20; i++) begin
      #1;
      check_state($sformatf("halted%0d", i), 6'b001000, Idle, 1'b1);
      opcode = 4'(i);
      tick();
    end
    rst = 1'b1;
    #1;
    check_state("hlt_rst", 6'b000001, Idle, 1'b0);
    @(negedge clk);
    rst    = 1'b0;
    opcode = 4'h0;
    #1;
    check_state("hlt_release", 6'b000001, WT1, 1'b0);

`ifdef SAP1_CTRL_STEP_EN
    step = 1'b0;
    #1;
    check_state("step_hold0", 6'b000001, Idle ^ MPcEn, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_state($sformatf("step_hold%0d", i + 1), 6'b000001, Idle ^ MPcEn, 1'b0);
    end
    step = 1'b1;
    #1;
    check_state("step_pulse", 6'b000001, WT1, 1'b0);
    tick();
    step = 1'b0;
    #1;
    check_state("step_adv", 6'b000010, WT2, 1'b0);
    tick();
    check_state("step_held", 6'b000010, WT2, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
